ni_tx_packetizer: RTL and testbench
===================================

# ni_tx_packetizer

Network-interface transmitter that turns a packet request (destination, length) plus a stream of data words into the HEADER/PAYLOAD/TAIL flit sequence the router's local input port consumes. It drives the router input FIFO through a valid/full stall handshake and presents, alongside each flit, the `flit_id` and the packet's `dst_addr`, exactly as the router's LBDR routing stage expects. One instance sits between each tile's core and its router's local port.

## Interface
- `DATA_W`, 32: flit payload width; must be ≥ 16.
- `LEN_W`, 8: width of the packet length field, counted in payload words.
- `SRC_ADDR`, 4'd5: this tile's mesh address, `{y[1:0], x[1:0]}`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-low.
- `pkt_valid` in 1: packet request valid.
- `pkt_ready` out 1: packet request accepted when `pkt_valid && pkt_ready`.
- `pkt_dst` in 4: destination address, `{y, x}`.
- `pkt_len` in `LEN_W`: number of payload words N.
- `data_valid` in 1: payload word valid.
- `data_ready` out 1: payload word accepted when `data_valid && data_ready`.
- `data_in` in `DATA_W`: payload word.
- `flit_valid` out 1: the output flit stage holds a flit.
- `fifo_full` in 1: the router input FIFO is full.
- `flit_out` out `DATA_W`: flit payload.
- `flit_id` out 3: `HEADER`, `PAYLOAD`, or `TAIL`, using the shared parameters include.
- `dst_addr` out 4: destination of the current packet, held constant across all of its flits.
- `pkt_count` out 16: packets whose TAIL has transferred. Present only with the stats option.
- `flit_count` out 16: flits transferred. Present only with the stats option.

## Operation
- A flit transfers on any rising edge where `flit_valid && !fifo_full`. While `fifo_full` is high, `flit_out`, `flit_id`, and `dst_addr` hold stable.
- The header flit payload is laid out as:
  - bits [3:0] = destination
  - bits [7:4] = `SRC_ADDR`
  - bits [8+LEN_W-1:8] = N
  - all remaining bits zero
- Each packet is a header followed by N flits. Flits 1 to N-1 are `PAYLOAD` and flit N is `TAIL`.
- If N = 0, the packet is a header followed by one `TAIL` whose payload is all zeros, and no data words are consumed.
- FSM states:
  - IDLE: `pkt_ready` = 1. When a packet request is accepted, latch the destination and N into `rem`, load the header flit, and go to HEAD.
  - HEAD: wait for the header to transfer. On transfer, go to BODY if N > 0. If N = 0, load the zero TAIL and go to LAST.
  - BODY: `data_ready = !flit_valid || !fifo_full`. On each accepted word, load the flit, tag it `TAIL` if `rem` == 1 and `PAYLOAD` otherwise, and decrement `rem`. Loading the TAIL moves the FSM to LAST.
  - LAST: wait for the TAIL to transfer, then return to IDLE.
- `data_ready` = 0 in every state except BODY. `pkt_ready` = 0 in every state except IDLE.
- `dst_addr` updates only when a packet is accepted in IDLE.
- Inputs arriving while the block is not ready are ignored, not buffered.

## Timing
- Reset (`rst` low at an edge): state IDLE and `rem` = 0. Outputs:
  - `pkt_ready` = 1
  - `data_ready` = 0
  - `flit_valid` = 0
  - `flit_out` = 0
  - `flit_id` = 0
  - `dst_addr` = 0
  - the counters = 0

  Reset mid-packet abandons the packet immediately. No TAIL is emitted.
- Packet accepted at edge t: the header is valid from t+1.
- With `fifo_full` held low, a data word presented with `data_valid` high from t+1 appears as a flit at t+2. Sustained throughput is then one flit per cycle.
- `data_ready` is registered-state-based plus `fifo_full` (combinational path from `fifo_full`). A transfer and a new load on the same edge are legal and lose no cycle.
- After the TAIL transfers at edge e, the FSM is in IDLE, so the next packet can be accepted at e+1. This is one bubble cycle between packets.
- If `fifo_full` rises while a flit is pending, that flit stays valid. `data_ready` drops the same cycle.
- With N = 2^LEN_W − 1, the length field carries all ones and `rem` must not wrap.

## Configuration
- `NI_TX_STATS_EN` defined:
  - `pkt_count` increments on each TAIL transfer.
  - `flit_count` increments on each flit transfer.
  - Both wrap modulo 2^16 and clear on reset.
- `NI_TX_STATS_EN` undefined: neither port nor its counter logic exists. All other behaviour is identical.

## Test plan
- Send dst = 4'hA, N = 2, data 0x11, 0x22, with `fifo_full` = 0. Required flits: `HEADER` with payload 0x0000_025A (N = 2, src 5, dst A), then `PAYLOAD` 0x11, then `TAIL` 0x22, on consecutive cycles. `dst_addr` = A on all three.
- Same packet with `fifo_full` high for 3 cycles while the header is pending. The header is held 3 extra cycles, `data_ready` = 0 throughout, and no flit is lost or duplicated.
- Send N = 0 with dst = 4'h5. Required flits: `HEADER` with payload 0x0000_0055, then `TAIL` 0. `data_ready` never asserts.
- Send two back-to-back N = 1 packets (dst 3, then dst C). Exactly one idle cycle separates the first TAIL from the second HEADER, and `dst_addr` changes only at the second HEADER.
- Pull `rst` low after the `PAYLOAD` of an N = 3 packet. On the next cycle, `flit_valid` = 0 and `pkt_ready` = 1. The next packet starts with a clean `HEADER`.
- With `NI_TX_STATS_EN` defined: after the first scenario, `pkt_count` = 1 and `flit_count` = 3. After reset, both are 0.

Source files
------------

// File: rtl/ni_tx_packetizer.sv
// NI transmitter: packet request + data words -> HEADER/PAYLOAD/TAIL flits toward the router local port.
// Optional `NI_TX_STATS_EN adds pkt_count / flit_count ports and their counters.
module ni_tx_packetizer #(
    parameter int          DATA_W   = 32,
    parameter int          LEN_W    = 8,
    parameter logic [3:0]  SRC_ADDR = 4'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [3:0]        pkt_dst,
    input  logic [LEN_W-1:0]  pkt_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              flit_valid,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] flit_out,
    output logic [2:0]        flit_id,
    output logic [3:0]        dst_addr
`ifdef NI_TX_STATS_EN
    ,
    output logic [15:0]       pkt_count,
    output logic [15:0]       flit_count
`endif
);

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef enum logic [1:0] {IDLE, HEAD, BODY, LAST} state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   flit_q, flit_d;
    logic [2:0]          id_q, id_d;
    logic [3:0]          dst_q, dst_d;
    logic [DATA_W-1:0]   hdr;
    logic                xfer;

    assign xfer = vld_q && !fifo_full;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        vld_d      = vld_q && !xfer;
        flit_d     = flit_q;
        id_d       = id_q;
        dst_d      = dst_q;
        pkt_ready  = 1'b0;
        data_ready = 1'b0;
        hdr                = '0;
        hdr[3:0]           = pkt_dst;
        hdr[7:4]           = SRC_ADDR;
        hdr[8 +: LEN_W]    = pkt_len;
        case (state_q)
            IDLE: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    dst_d   = pkt_dst;
                    rem_d   = pkt_len;
                    flit_d  = hdr;
                    id_d    = HEADER;
                    vld_d   = 1'b1;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (xfer) begin
                    if (rem_q != '0) begin
                        state_d = BODY;
                    end else begin
                        // Zero-length packet still closes with an all-zero TAIL.
                        flit_d  = '0;
                        id_d    = TAIL;
                        vld_d   = 1'b1;
                        state_d = LAST;
                    end
                end
            end
            BODY: begin
                // Load on the same edge the pending flit leaves, keeping one flit per cycle.
                data_ready = !vld_q || !fifo_full;
                if (data_valid && data_ready) begin
                    flit_d = data_in;
                    vld_d  = 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        id_d    = TAIL;
                        state_d = LAST;
                    end else begin
                        id_d    = PAYLOAD;
                    end
                end
            end
            LAST: begin
                if (xfer) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            vld_q   <= 1'b0;
            flit_q  <= '0;
            id_q    <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            flit_q  <= flit_d;
            id_q    <= id_d;
            dst_q   <= dst_d;
        end
    end

    assign flit_valid = vld_q;
    assign flit_out   = flit_q;
    assign flit_id    = id_q;
    assign dst_addr   = dst_q;

`ifdef NI_TX_STATS_EN
    logic [15:0] pkt_cnt_q, flit_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
        end else if (xfer) begin
            flit_cnt_q <= flit_cnt_q + 16'd1;
            if (id_q == TAIL) pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign flit_count = flit_cnt_q;
`endif

endmodule

// File: tb/tb_ni_tx_packetizer.sv
// Scoreboard bench for ni_tx_packetizer: directed packets, stalls, reset mid-packet, max length.
module tb_ni_tx_packetizer;

    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] data;
        logic [3:0]  dst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [3:0]  pkt_dst = '0;
    logic [7:0]  pkt_len = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data_in = '0;
    logic        flit_valid;
    logic        fifo_full = 1'b0;
    logic [31:0] flit_out;
    logic [2:0]  flit_id;
    logic [3:0]  dst_addr;
`ifdef NI_TX_STATS_EN
    logic [15:0] pkt_count, flit_count;
`endif

    ni_tx_packetizer #(.DATA_W(32), .LEN_W(8), .SRC_ADDR(4'd5)) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_valid(flit_valid), .fifo_full(fifo_full),
        .flit_out(flit_out), .flit_id(flit_id), .dst_addr(dst_addr)
`ifdef NI_TX_STATS_EN
        , .pkt_count(pkt_count), .flit_count(flit_count)
`endif
    );

    always #5 clk = ~clk;

    exp_t        sbq[$];
    logic [31:0] wq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_tail_cyc = 0;
    int          last_hdr_cyc  = 0;
    logic        dr_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every transferring flit is matched against the head of the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst && data_ready) dr_seen = 1'b1;
        if (rst && flit_valid && !fifo_full) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit actual=%0h required=none", {flit_id, flit_out});
            end else begin
                e = sbq.pop_front();
                chk("flit", {25'd0, flit_id, flit_out, dst_addr}, {25'd0, e.id, e.data, e.dst});
                if (flit_id == TAIL)   last_tail_cyc = cyc;
                if (flit_id == HEADER) last_hdr_cyc  = cyc;
            end
        end
    end

    task automatic accept_pkt(input logic [3:0] dst, input logic [7:0] len, input logic [31:0] hdr);
        int n = 0;
        sbq.push_back('{HEADER, hdr, dst});
        pkt_dst = dst; pkt_len = len; pkt_valid = 1'b1;
        @(negedge clk);
        while (!pkt_ready && n < 100) begin @(negedge clk); n++; end
        if (!pkt_ready) chk("pkt_ready_timeout", {63'd0, pkt_ready}, 64'd1);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        data_in = w; data_valid = 1'b1;
        @(negedge clk);
        while (!data_ready && n < 100) begin @(negedge clk); n++; end
        if (!data_ready) chk("data_ready_timeout", {63'd0, data_ready}, 64'd1);
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic send_words(input logic [3:0] dst);
        for (int i = 0; i < wq.size(); i++) begin
            sbq.push_back('{(i == wq.size() - 1) ? TAIL : PAYLOAD, wq[i], dst});
            send_word(wq[i]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
        #1;
    endtask

    initial begin
        int t_tail, t_hdr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pkt_ready",  {63'd0, pkt_ready},  64'd1);
        chk("rst_data_ready", {63'd0, data_ready}, 64'd0);
        chk("rst_flit_valid", {63'd0, flit_valid}, 64'd0);
        chk("rst_flit_out",   {32'd0, flit_out},   64'd0);
        chk("rst_flit_id",    {61'd0, flit_id},    64'd0);
        chk("rst_dst_addr",   {60'd0, dst_addr},   64'd0);
`ifdef NI_TX_STATS_EN
        chk("rst_counts", {32'd0, pkt_count, flit_count}, 64'd0);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic N=2 packet
        accept_pkt(4'hA, 8'd2, 32'h0000_025A);
        wq = '{32'h11, 32'h22};
        send_words(4'hA);
        drain();
`ifdef NI_TX_STATS_EN
        chk("stats_pkt",  {48'd0, pkt_count},  64'd1);
        chk("stats_flit", {48'd0, flit_count}, 64'd3);
`endif

        // Header stalled for three cycles by fifo_full
        accept_pkt(4'hA, 8'd2, 32'h0000_025A);
        fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_data_ready", {63'd0, data_ready}, 64'd0);
            chk("stall_hold", {28'd0, flit_valid, flit_id, flit_out}, {28'd0, 1'b1, HEADER, 32'h0000_025A});
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        wq = '{32'h11, 32'h22};
        send_words(4'hA);
        drain();

        // Zero-length packet
        dr_seen = 1'b0;
        accept_pkt(4'h5, 8'd0, 32'h0000_0055);
        sbq.push_back('{TAIL, 32'h0, 4'h5});
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("n0_no_data_ready", {63'd0, dr_seen}, 64'd0);

        // Back-to-back N=1 packets: one bubble between TAIL and next HEADER
        accept_pkt(4'h3, 8'd1, 32'h0000_0153);
        wq = '{32'hA1};
        send_words(4'h3);
        accept_pkt(4'hC, 8'd1, 32'h0000_015C);
        t_tail = last_tail_cyc;
        wq = '{32'hB2};
        send_words(4'hC);
        t_hdr = last_hdr_cyc;
        drain();
        chk("b2b_gap", 64'(t_hdr - t_tail), 64'd2);

        // Reset mid-packet with a flit pending
        accept_pkt(4'h7, 8'd3, 32'h0000_0357);
        sbq.push_back('{PAYLOAD, 32'h31, 4'h7});
        send_word(32'h31);
        drain();
        fifo_full = 1'b1;
        send_word(32'h32);
        @(negedge clk);
        chk("pre_rst_pending", {63'd0, flit_valid}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        fifo_full = 1'b0;
        @(negedge clk);
        chk("midrst_flit_valid", {63'd0, flit_valid}, 64'd0);
        chk("midrst_pkt_ready",  {63'd0, pkt_ready},  64'd1);
        chk("midrst_data_ready", {63'd0, data_ready}, 64'd0);
`ifdef NI_TX_STATS_EN
        chk("midrst_counts", {32'd0, pkt_count, flit_count}, 64'd0);
`endif
        @(posedge clk); #1;
        accept_pkt(4'h6, 8'd1, 32'h0000_0156);
        wq = '{32'h66};
        send_words(4'h6);
        drain();

        // Maximum length: rem must count 255 words without wrapping
        accept_pkt(4'h9, 8'hFF, 32'h0000_FF59);
        wq = {};
        for (int i = 1; i <= 255; i++) wq.push_back(32'(i) | 32'h5A00_0000);
        send_words(4'h9);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("final_idle", {62'd0, flit_valid, pkt_ready}, 64'd1);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
